// File: rtl/button_reader_pkg.sv
// Shared constants and bus request type for the button_reader peripheral.
package button_reader_pkg;
  localparam int   BUS_DATA_W              = 32;
  localparam logic BUTTON_ADDR_LEVEL       = 1'b0;
  localparam logic BUTTON_ADDR_EVENTS      = 1'b1;
  localparam int   DEFAULT_DEBOUNCE_CYCLES = 270000;

  typedef struct packed {
    logic                  rd;
    logic                  wr;
    logic                  addr;
    logic [BUS_DATA_W-1:0] wdata;
  } bus_req_t;
endpackage

// File: rtl/button_reader_debouncer.sv
// Single-bit 2-flop synchroniser plus saturating-hold debouncer; rise pulses
// in the cycle before stable goes 0->1 so the parent can latch it on the same edge.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_n,
  output logic stable,
  output logic rise
);
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q;
  logic          s;
  logic          accept;

  assign s      = ~sync_q[1];
  assign accept = (s != stable) && (cnt_q == CNT_MAX);
  assign rise   = accept & s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
      cnt_q  <= '0;
      stable <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], raw_n};
      if (s == stable) begin
        cnt_q <= '0;
      end else if (accept) begin
        stable <= s;
        cnt_q  <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end
endmodule

// File: rtl/button_reader.sv
// Memory-mapped button input: LEVEL (debounced) and sticky EVENTS (press flags).
// Define BUTTON_READER_IRQ_EN to build the registered event-pending irq.
module button_reader
  import button_reader_pkg::*;
#(
  parameter int NUM_BUTTONS     = 2,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_BUTTONS-1:0] buttons_n,
  input  logic                   read_enable,
  input  logic                   write_enable,
  input  logic                   address,
  input  logic [BUS_DATA_W-1:0]  data_in,
  output logic [BUS_DATA_W-1:0]  data_out,
  output logic                   irq
);
  localparam logic [BUS_DATA_W-1:0] BTN_MASK =
    (NUM_BUTTONS >= BUS_DATA_W) ? '1 : BUS_DATA_W'((64'd1 << NUM_BUTTONS) - 64'd1);

  bus_req_t                 req;
  logic [NUM_BUTTONS-1:0]   stable;
  logic [NUM_BUTTONS-1:0]   rise;
  logic [BUS_DATA_W-1:0]    stable_w, rise_w, clr_w, rd_data;
  logic [BUS_DATA_W-1:0]    events_q, events_d;

  assign req = '{rd: read_enable, wr: write_enable, addr: address, wdata: data_in};

  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_btn
    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk    (clk),
      .rst_n  (rst_n),
      .raw_n  (buttons_n[i]),
      .stable (stable[i]),
      .rise   (rise[i])
    );
  end

  // Events live in a bus-width vector; bits above NUM_BUTTONS are masked to 0.
  always_comb begin
    stable_w = '0;
    rise_w   = '0;
    stable_w[NUM_BUTTONS-1:0] = stable;
    rise_w[NUM_BUTTONS-1:0]   = rise;
    clr_w = '0;
    if (req.addr == BUTTON_ADDR_EVENTS) begin
      if (req.rd) clr_w = clr_w | events_q;
      if (req.wr) clr_w = clr_w | req.wdata;
    end
    // A press landing in the same cycle as a clear keeps its bit set.
    events_d = ((events_q & ~clr_w) | rise_w) & BTN_MASK;
    rd_data  = (req.addr == BUTTON_ADDR_EVENTS) ? events_q : stable_w;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      events_q <= '0;
      data_out <= '0;
    end else begin
      events_q <= events_d;
      if (req.rd) data_out <= rd_data;
    end
  end

`ifdef BUTTON_READER_IRQ_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq <= 1'b0;
    else        irq <= |events_d;
  end
`else
  assign irq = 1'b0;
`endif
endmodule

// File: tb/tb_button_reader.sv
// Directed bench for button_reader with DEBOUNCE_CYCLES=4, NUM_BUTTONS=2.
module tb_button_reader;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  buttons_n;
  logic        read_enable, write_enable, address;
  logic [31:0] data_in, data_out;
  logic        irq;
  int          n_checks = 0;
  int          n_fail   = 0;

`ifdef BUTTON_READER_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif

  button_reader #(.NUM_BUTTONS(2), .DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .buttons_n(buttons_n),
    .read_enable(read_enable), .write_enable(write_enable), .address(address),
    .data_in(data_in), .data_out(data_out), .irq(irq)
  );

  always #5 clk = ~clk;

  // All stimulus changes at negedges; outputs are sampled at negedges.
  task automatic do_read(input logic a, output logic [31:0] d);
    read_enable = 1'b1;
    address     = a;
    @(negedge clk);
    read_enable = 1'b0;
    d = data_out;
  endtask

  task automatic do_write(input logic a, input logic [31:0] d);
    write_enable = 1'b1;
    address      = a;
    data_in      = d;
    @(negedge clk);
    write_enable = 1'b0;
    data_in      = '0;
  endtask

  task automatic test_reset;
    logic [31:0] d;
    rst_n = 1'b0;
    buttons_n = 2'b11;
    read_enable = 1'b0; write_enable = 1'b0; address = 1'b0; data_in = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (data_out !== 32'h0 || irq !== 1'b0) begin
      n_fail++; $display("FAIL reset_hold: data_out=%h irq=%b, want 0/0", data_out, irq);
    end
    rst_n = 1'b1;
    @(negedge clk);
    do_read(1'b0, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL reset_level: got %h want 0", d); end
    do_read(1'b1, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL reset_events: got %h want 0", d); end
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b want 0", irq); end
  endtask

  task automatic test_clean_press;
    logic [31:0] d;
    buttons_n = 2'b10;
    repeat (10) @(negedge clk);
    n_checks++;
    if (irq !== IRQ_ON) begin n_fail++; $display("FAIL press_irq: got %b want %b", irq, IRQ_ON); end
    do_read(1'b0, d);
    n_checks++;
    if (d !== 32'h1) begin n_fail++; $display("FAIL press_level: got %h want 1", d); end
    do_read(1'b1, d);
    n_checks++;
    if (d !== 32'h1) begin n_fail++; $display("FAIL press_events: got %h want 1", d); end
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL press_irq_clr: got %b want 0", irq); end
    do_read(1'b1, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL press_events_cleared: got %h want 0", d); end
    buttons_n = 2'b11;
    repeat (10) @(negedge clk);
    do_read(1'b0, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL release_level: got %h want 0", d); end
    do_read(1'b1, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL release_no_event: got %h want 0", d); end
  endtask

  task automatic test_glitch;
    logic [31:0] d;
    buttons_n = 2'b01;
    repeat (3) @(negedge clk);
    buttons_n = 2'b11;
    repeat (10) @(negedge clk);
    do_read(1'b0, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL glitch_level: got %h want 0", d); end
    do_read(1'b1, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL glitch_events: got %h want 0", d); end
  endtask

  // A pulse of exactly DEBOUNCE_CYCLES is the shortest one accepted.
  task automatic test_min_pulse;
    logic [31:0] d;
    buttons_n = 2'b01;
    repeat (4) @(negedge clk);
    buttons_n = 2'b11;
    repeat (12) @(negedge clk);
    do_read(1'b1, d);
    n_checks++;
    if (d !== 32'h2) begin n_fail++; $display("FAIL min_pulse_events: got %h want 2", d); end
    do_read(1'b0, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL min_pulse_level: got %h want 0", d); end
  endtask

  task automatic test_w1c;
    logic [31:0] d;
    buttons_n = 2'b00;
    repeat (10) @(negedge clk);
    do_write(1'b1, 32'h2);
    do_write(1'b0, 32'h3);
    do_read(1'b1, d);
    n_checks++;
    if (d !== 32'h1) begin n_fail++; $display("FAIL w1c_events: got %h want 1", d); end
    do_read(1'b0, d);
    n_checks++;
    if (d !== 32'h3) begin n_fail++; $display("FAIL w1c_level: got %h want 3", d); end
    buttons_n = 2'b11;
    repeat (10) @(negedge clk);
    do_read(1'b1, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL w1c_after_release: got %h want 0", d); end
  endtask

  // Press edge is set before posedge 1; stable rises on posedge 2+4=6, which
  // is exactly the edge the EVENTS read samples.
  task automatic test_simul_event_clear;
    logic [31:0] d;
    buttons_n = 2'b10;
    repeat (5) @(negedge clk);
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL simul_irq_before: got %b want 0", irq); end
    do_read(1'b1, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL simul_read: got %h want 0", d); end
    n_checks++;
    if (irq !== IRQ_ON) begin n_fail++; $display("FAIL simul_irq_set: got %b want %b", irq, IRQ_ON); end
    do_read(1'b1, d);
    n_checks++;
    if (d !== 32'h1) begin n_fail++; $display("FAIL simul_next_read: got %h want 1", d); end
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL simul_irq_clr: got %b want 0", irq); end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_glitch();
    test_min_pulse();
    test_w1c();
    test_simul_event_clear();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/button_reader.md
Name: button_reader

Overview:
- Memory-mapped input peripheral: the read-side counterpart of the write-only LED register.
- Samples NUM_BUTTONS active-low board push-buttons, synchronises and debounces them, and latches press events.
- Presents debounced level and sticky press-event flags to the CPU bus through a registered read port.
- Events are cleared by reading them or by writing 1 to the event bits.

Parameters:
- NUM_BUTTONS, 2: number of button inputs, 1..32.
- DEBOUNCE_CYCLES, 270000: consecutive cycles an input must hold a new value before it is accepted (about 10 ms at 27 MHz); minimum 2.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- buttons_n  input  NUM_BUTTONS  raw pins, 0 = pressed, asynchronous to clk.
- read_enable  input  1  bus read strobe.
- write_enable  input  1  bus write strobe.
- address  input  1  register select: 0 = LEVEL, 1 = EVENTS.
- data_in  input  32  write data; only EVENTS is writable.
- data_out  output  32  registered read data.
- irq  output  1  event-pending interrupt (see Optional Feature).

Behaviour:
- Reset (asynchronous, rst_n low):
  - Sync flops = 1 (released); stable = released; counters = 0; events = 0.
  - data_out = 0; irq = 0.
  - Reset mid-debounce discards the count.
- Synchroniser: 2-flop chain per bit. Synchronised value s = inverted second flop, so 1 = pressed.
- Debounce, per bit:
  - s == stable: counter cleared to 0.
  - s != stable: counter increments.
  - When the counter equals DEBOUNCE_CYCLES-1 and s still differs, stable <= s and the counter clears.
  - Any glitch shorter than DEBOUNCE_CYCLES cycles is rejected.
  - Counter width is clog2(DEBOUNCE_CYCLES); the counter never wraps.
- Press event: stable changing 0->1 sets events[i] in the same cycle stable updates. Release does not set an event.
- Total latency from a pin edge to stable/events updating = 2 sync cycles + DEBOUNCE_CYCLES cycles.
- Read (read_enable=1):
  - data_out is loaded on the next rising edge: 1-cycle read latency.
  - address 0 returns {zeros, stable}. address 1 returns {zeros, events}.
  - Upper 32-NUM_BUTTONS bits always read 0.
  - When read_enable=0, data_out holds its last value.
- Read-to-clear: a read of EVENTS clears exactly the bits returned. A new press event on bit i in the same cycle wins: events[i] stays 1.
- Write (write_enable=1, address 1): events <= events & ~data_in[NUM_BUTTONS-1:0], i.e. write-1-to-clear. A simultaneous new event on a bit wins over the clear.
- Write to address 0: ignored.
- read_enable and write_enable both high: the read executes as specified and the write's clear is also applied.

Optional Feature:
- Macro: BUTTON_READER_IRQ_EN.
- Defined: irq is a register, irq <= |events_next. It asserts one cycle after the event set and deasserts one cycle after the last event clears.
- Undefined: irq tied to constant 0 and no irq logic is generated; all other behaviour is identical.

Decomposition:
- Shared package/header:
  - Register offset constants BUTTON_ADDR_LEVEL=0 and BUTTON_ADDR_EVENTS=1.
  - Default DEBOUNCE_CYCLES constant.
  - Bus data width constant 32.
- Sub-module button_debouncer:
  - Contents: one synchroniser, counter and stable flop for a single bit.
  - Parameters: DEBOUNCE_CYCLES; ports clk, rst_n, raw_n, stable, rise.
  - Instantiated NUM_BUTTONS times by a generate loop.
- Top level holds the event register, read mux, data_out and irq.

Test Plan (DEBOUNCE_CYCLES=4, NUM_BUTTONS=2):
- Reset: hold rst_n=0, buttons_n=2'b11, release, read address 0 and 1 -> data_out=0 both; irq=0.
- Clean press: buttons_n=2'b10 held 10 cycles -> LEVEL reads 32'h1; EVENTS reads 32'h1; immediate second EVENTS read returns 32'h0.
- Glitch rejection: buttons_n[1] low for 3 cycles then high -> LEVEL stays 0, EVENTS stays 0.
- Write-1-to-clear: press both buttons, wait 10 cycles, write data_in=32'h2 to address 1 -> EVENTS reads 32'h1; LEVEL still reads 32'h3.
- Simultaneous event and clear: schedule button 0's stable rise in the same cycle as an EVENTS read -> that read returns 0 for bit 0, next read returns 32'h1.
- With BUTTON_READER_IRQ_EN: press button 0 -> irq=1 one cycle after event set; read EVENTS -> irq=0 one cycle later. Without the macro, irq stays 0 throughout.
